// File: rtl/output_record_serializer.sv
// Captures changed 40-bit output records into a circular FIFO and streams each one
// out as five bytes, MSB first, over a valid/ready byte interface.
module output_record_serializer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] data,
    input  logic        enable,
    input  logic        clear_ovf,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic [4:0]  fifo_count,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    typedef enum logic {StIdle, StSend} state_t;

    state_t        r_state;
    logic [39:0]   r_shreg;
    logic [2:0]    r_idx;
    logic [39:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic          r_overflow;
    logic [39:0]   r_last_rec;
    logic          r_last_valid;

    logic        w_send;
    logic        w_last_beat;
    logic        w_pop;
    logic        w_new;
    logic        w_push;
    logic        w_drop;
    logic [39:0] w_head;

    assign w_send      = (r_state == StSend);
    assign w_last_beat = w_send && tx_ready && (r_idx == 3'd4);
    // The head is taken either from idle or on the final beat, so records chain with no bubble.
    assign w_pop       = (r_count != 5'd0) && (!w_send || w_last_beat);
    assign w_head      = r_mem[r_rptr];
    assign w_new       = enable && (!r_last_valid || (data != r_last_rec));
    assign w_push      = w_new && ((r_count != DEPTH_C) || w_pop);
    assign w_drop      = w_new && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_last_rec   <= '0;
            r_last_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            // A drop wins over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
            if (enable) begin
                r_last_rec   <= data;
                r_last_valid <= 1'b1;
            end else begin
                r_last_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_shreg <= '0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_shreg <= w_head;
                        r_idx   <= '0;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        if (r_idx != 3'd4) begin
                            r_shreg <= {r_shreg[31:0], 8'h00};
                            r_idx   <= r_idx + 3'd1;
                        end else if (w_pop) begin
                            r_shreg <= w_head;
                            r_idx   <= '0;
                        end else begin
                            // Clear so tx_data reads zero while idle.
                            r_shreg <= '0;
                            r_idx   <= '0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tx_data    = r_shreg[39:32];
    assign tx_valid   = w_send;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = w_send || (r_count != 5'd0);

endmodule

// File: tb/tb_output_record_serializer.sv
// Directed bench for output_record_serializer: a per-cycle vector table for the basic
// capture/stream behaviour, then hand-written sequences for the multi-cycle corner cases.
module tb_output_record_serializer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] data;
    logic        enable;
    logic        clear_ovf;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    output_record_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .enable     (enable),
        .clear_ovf  (clear_ovf),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [39:0] d;
        logic        rdy;
        logic        clr;
        logic [15:0] exp; // {tx_valid, tx_data, fifo_count, overflow, busy}
    } vec_t;

    function automatic logic [15:0] status();
        return {tx_valid, tx_data, fifo_count, overflow, busy};
    endfunction

    function automatic logic [15:0] st(input logic v, input logic [7:0] d, input logic [4:0] c,
                                       input logic o, input logic b);
        return {v, d, c, o, b};
    endfunction

    function automatic logic [39:0] rec(input int k);
        return {16'h1000 + 16'(k), 24'hA00000 + 24'(k)};
    endfunction

    function automatic logic [7:0] byte_of(input logic [39:0] r, input int j);
        logic [39:0] t;
        t = r >> (8 * (4 - j));
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, then step one rising edge and settle just past it.
    task automatic apply(input logic en, input logic [39:0] d, input logic rdy, input logic clr);
        enable    = en;
        data      = d;
        tx_ready  = rdy;
        clear_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [39:0] R = 40'h0012_ABCDEF;

    vec_t tbl [15];
    int   order [9];

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        data      = '0;
        clear_ovf = 1'b0;
        tx_ready  = 1'b0;

        tbl[0]  = '{1'b1, R,     1'b1, 1'b0, st(1'b0, 8'h00, 5'd1, 1'b0, 1'b1)};
        tbl[1]  = '{1'b1, R,     1'b1, 1'b0, st(1'b1, 8'h00, 5'd0, 1'b0, 1'b1)};
        tbl[2]  = '{1'b1, R,     1'b1, 1'b0, st(1'b1, 8'h12, 5'd0, 1'b0, 1'b1)};
        tbl[3]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hAB, 5'd0, 1'b0, 1'b1)};
        tbl[4]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hCD, 5'd0, 1'b0, 1'b1)};
        tbl[5]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hEF, 5'd0, 1'b0, 1'b1)};
        tbl[6]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b0, 8'h00, 5'd0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b0, 8'h00, 5'd0, 1'b0, 1'b0)};
        tbl[8]  = '{1'b1, R,     1'b1, 1'b0, st(1'b0, 8'h00, 5'd1, 1'b0, 1'b1)};
        tbl[9]  = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'h00, 5'd0, 1'b0, 1'b1)};
        tbl[10] = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'h12, 5'd0, 1'b0, 1'b1)};
        tbl[11] = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hAB, 5'd0, 1'b0, 1'b1)};
        tbl[12] = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hCD, 5'd0, 1'b0, 1'b1)};
        tbl[13] = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b1, 8'hEF, 5'd0, 1'b0, 1'b1)};
        tbl[14] = '{1'b0, 40'd0, 1'b1, 1'b0, st(1'b0, 8'h00, 5'd0, 1'b0, 1'b0)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset status", 40'(status()), 40'd0);
        reset = 1'b1;

        // Single record, repeated enable, enable-gap recapture
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].en, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("table vec %0d", i), 40'(status()), 40'(tbl[i].exp));
        end

        // Backpressure held on byte 2
        apply(1'b1, R, 1'b1, 1'b0);
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp byte0", {tx_valid, tx_data}, {1'b1, 8'h00});
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp byte1", {tx_valid, tx_data}, {1'b1, 8'h12});
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp byte2", {tx_valid, tx_data}, {1'b1, 8'hAB});
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            chk("bp stall", {tx_valid, tx_data}, {1'b1, 8'hAB});
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp byte3", {tx_valid, tx_data}, {1'b1, 8'hCD});
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp byte4", {tx_valid, tx_data}, {1'b1, 8'hEF});
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("bp idle", {tx_valid, busy}, 2'b00);

        // Back-to-back records stream as 10 contiguous beats
        apply(1'b1, rec(1), 1'b1, 1'b0);
        apply(1'b1, rec(2), 1'b1, 1'b0);
        chk("b2b count", 40'(fifo_count), 40'd1);
        for (int k = 0; k < 10; k++) begin
            chk("b2b beat", {tx_valid, tx_data}, {1'b1, byte_of(rec(1 + k / 5), k % 5)});
            apply(1'b0, '0, 1'b1, 1'b0);
        end
        chk("b2b idle", {tx_valid, busy}, 2'b00);

        // Overflow: one record sits in the shift register, so DEPTH+1 survive and the last drops
        chk("ovf start", 40'(overflow), 40'd0);
        for (int k = 1; k <= DEPTH + 2; k++) begin
            apply(1'b1, rec(k), 1'b0, 1'b0);
        end
        chk("ovf count", 40'(fifo_count), 40'(DEPTH));
        chk("ovf flag", 40'(overflow), 40'd1);
        chk("ovf head", {tx_valid, tx_data}, {1'b1, byte_of(rec(1), 0)});
        for (int r = 1; r <= DEPTH + 1; r++) begin
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("ovf drain r%0d b%0d", r, j), {tx_valid, tx_data},
                    {1'b1, byte_of(rec(r), j)});
                apply(1'b0, '0, 1'b1, 1'b0);
            end
        end
        chk("ovf drained", {tx_valid, busy, fifo_count}, 40'd0);
        chk("ovf sticky", 40'(overflow), 40'd1);
        apply(1'b0, '0, 1'b0, 1'b1);
        chk("ovf clear", 40'(overflow), 40'd0);

        // Full FIFO with a pop on the same edge as a new capture
        for (int k = 1; k <= DEPTH + 1; k++) begin
            apply(1'b1, rec(k), 1'b0, 1'b0);
        end
        chk("full count", 40'(fifo_count), 40'(DEPTH));
        for (int j = 0; j < 4; j++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
        end
        chk("full last beat", {tx_valid, tx_data}, {1'b1, byte_of(rec(1), 4)});
        apply(1'b1, rec(11), 1'b1, 1'b0);
        chk("full pop+push count", 40'(fifo_count), 40'(DEPTH));
        chk("full pop+push ovf", 40'(overflow), 40'd0);
        for (int i = 0; i < 8; i++) begin
            order[i] = i + 2;
        end
        order[8] = 11;
        for (int r = 0; r < 9; r++) begin
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("full drain r%0d b%0d", order[r], j), {tx_valid, tx_data},
                    {1'b1, byte_of(rec(order[r]), j)});
                apply(1'b0, '0, 1'b1, 1'b0);
            end
        end
        chk("full drained", 40'(status()), 40'd0);

        // Reset mid-record with three queued
        for (int k = 1; k <= 4; k++) begin
            apply(1'b1, rec(k), 1'b0, 1'b0);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("rst pre byte2", {tx_valid, tx_data, fifo_count}, {1'b1, byte_of(rec(1), 2), 5'd3});
        #2;
        reset = 1'b0;
        #1;
        chk("rst async", 40'(status()), 40'd0);
        @(posedge clk);
        #1;
        chk("rst held", 40'(status()), 40'd0);
        reset = 1'b1;
        apply(1'b1, R, 1'b1, 1'b0);
        chk("rst first edge capture", 40'(status()), 40'(st(1'b0, 8'h00, 5'd1, 1'b0, 1'b1)));
        for (int j = 0; j < 5; j++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            chk("rst fresh beat", {tx_valid, tx_data, fifo_count},
                {1'b1, byte_of(R, j), 5'd0});
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("rst final idle", 40'(status()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
